fetch_queue: RTL and testbench

//  Instruction prefetch queue between the fetch PC and the IF/ID buffer. Owns the fetch PC.

---
 rtl/fetch_queue.sv | 164 ++++++++++++++++
 tb/tb_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue owning the fetch PC
//
// Sits between the fetch PC and the IF/ID buffer. Word fetches go out to a
// variable-latency instruction memory over a req/ack handshake; each returned
// word is queued as {pc+4, instr}; decode pops entries with valid/ready.
// A redirect flushes the queue and restarts fetch at redirect_pc.
//
// Parameters:
//   DEPTH     queue entries, power of two, >= 2
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   redirect, redirect_pc  flush and restart fetch at the word-aligned target
//   imem_req, imem_addr    fetch request (held until ack) and its address
//   imem_ack, imem_data    response strobe (ends the request) and fetched word
//   deq_valid, deq_ready   head-entry handshake toward decode
//   deq_instr, deq_pc4     head instruction and its fetch address + 4
//   count                  occupied entries
//
// Build option:
//   FQ_BYPASS_EN  when defined, a fetch returning into an empty queue is
//                 presented on deq_* in the ack cycle; if decode takes it, it
//                 is never written. When undefined, deq_* come only from
//                 queue storage (no imem_* to deq_* combinational path).

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_data,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_instr,
    output logic [31:0]                deq_pc4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   drop_addr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc4   [DEPTH];

    logic [31:0]   fetch_pc4;
    logic          q_nonempty;
    logic          take;
    logic          bypass_pop;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;

    assign fetch_pc4  = fetch_pc + 32'd4;
    assign q_nonempty = (count_q != '0);

    // A response is kept only when it answers a live WAIT request and no
    // redirect is discarding it in the same cycle.
    assign take = (state == S_WAIT) && imem_ack && !redirect;

`ifdef FQ_BYPASS_EN
    // Empty queue and decode ready: the word goes straight through.
    assign bypass_pop = take && !q_nonempty && deq_ready;
`else
    assign bypass_pop = 1'b0;
`endif

    assign push = take && !bypass_pop;
    assign pop  = q_nonempty && deq_ready && !redirect;

    assign count_next = count_q + CW'(push) - CW'(pop);

    assign imem_req  = (state != S_IDLE);
    assign imem_addr = (state == S_DROP) ? drop_addr : fetch_pc;
    assign count     = count_q;

    // Data outputs are masked with the occupancy so that they read zero
    // whenever the queue is empty, including immediately on reset.
    always_comb begin
        deq_valid = q_nonempty && !redirect;
        deq_instr = q_nonempty ? mem_instr[rd_ptr] : 32'h0;
        deq_pc4   = q_nonempty ? mem_pc4[rd_ptr]   : 32'h0;
`ifdef FQ_BYPASS_EN
        if (take && !q_nonempty) begin
            deq_valid = 1'b1;
            deq_instr = imem_data;
            deq_pc4   = fetch_pc4;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_data;
            mem_pc4[wr_ptr]   <= fetch_pc4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= 32'h0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
        end else begin
            // Redirect wins over any push or pop this cycle.
            if (redirect) begin
                count_q  <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= redirect_pc;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count_q <= count_next;
                if (take) fetch_pc <= fetch_pc4;
            end

            case (state)
                S_IDLE: begin
                    if ((count_q < CW'(DEPTH)) && !redirect) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        // With redirect the data is dropped and the new
                        // target is requested next cycle.
                        if (redirect)                       state <= S_WAIT;
                        else if (count_next < CW'(DEPTH))   state <= S_WAIT;
                        else                                state <= S_IDLE;
                    end else if (redirect) begin
                        // The memory still owes a response for the old
                        // address; keep presenting it until it arrives.
                        state     <= S_DROP;
                        drop_addr <= fetch_pc;
                    end
                end
                S_DROP: begin
                    if (imem_ack) state <= S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc4;
    logic [2:0]  count;

    int n_run  = 0;
    int n_fail = 0;

    int   lat = 1;
    int   budget = 0;
    logic force_ack = 1'b0;
    int   wcnt;

    logic [63:0] sb [$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr), .deq_pc4(deq_pc4),
        .count(count)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    // Memory model: ack after lat cycles of request, limited by an ack budget.
    assign imem_ack  = force_ack | (imem_req && (budget > 0) && (wcnt >= lat - 1));
    assign imem_data = force_ack ? 32'hDEAD_BEEF : memf(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end

    always @(posedge clk) begin
        if (rst_n && imem_ack && !force_ack && budget > 0) budget <= budget - 1;
    end

    // Monitor: every accepted head entry must match the scoreboard front.
    always @(negedge clk) begin
        if (rst_n && deq_valid && deq_ready) begin
            n_run++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL deq_unexpected actual pc4=%h instr=%h required none", deq_pc4, deq_instr);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({deq_pc4, deq_instr} !== e) begin
                    n_fail++;
                    $display("FAIL deq_entry actual pc4=%h instr=%h required pc4=%h instr=%h",
                             deq_pc4, deq_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr);
        sb.push_back({addr + 32'd4, memf(addr)});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; deq_ready = 1'b0; redirect = 1'b0; budget = 0;
        force_ack = 1'b0; lat = 1;
        repeat (2) cyc();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, deq_valid}, 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_instr", deq_instr, 32'h0);
        chk("rst_pc4", deq_pc4, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 60 && sb.size() != 0; k++) cyc();
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'h0);
        repeat (4) cyc();
    endtask

    task automatic wait_count(input logic [2:0] n, input string name);
        int k;
        for (k = 0; k < 20 && count != n; k++) cyc();
        chk(name, 32'(count), 32'(n));
    endtask

    initial begin
        #2 rst_n = 1'b0;

        // 1: single-cycle memory, decode always ready
        apply_reset();
        lat = 1; budget = 8; deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'(4 * i));
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("s1_addr", imem_addr, 32'(4 * i));
            chk("s1_req", {31'b0, imem_req}, 32'h1);
`ifdef FQ_BYPASS_EN
            chk("s1_count_zero", 32'(count), 32'h0);
            chk("s1_bypass_valid", {31'b0, deq_valid}, 32'h1);
`else
            chk("s1_count_le1", {31'b0, (count <= 3'd1)}, 32'h1);
`endif
        end
        drain("s1");

        // 2: fill to full, then drain in order and resume at 0x10
        apply_reset();
        lat = 1; budget = 4; deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(32'(4 * i));
        @(posedge clk);
        repeat (4) cyc();
        @(negedge clk);
        chk("s2_full_count", 32'(count), 32'h4);
        chk("s2_full_req", {31'b0, imem_req}, 32'h0);
        cyc();
        deq_ready = 1'b1;
        for (int k = 0; k < 10 && !imem_req; k++) cyc();
        chk("s2_resume_req", {31'b0, imem_req}, 32'h1);
        chk("s2_resume_addr", imem_addr, 32'h10);
        drain("s2");

        // 3: 3-cycle memory, redirect one cycle into WAIT
        apply_reset();
        lat = 3; budget = 4; deq_ready = 1'b1;
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        @(posedge clk);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("s3_redir_valid", {31'b0, deq_valid}, 32'h0);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("s3_drop_req", {31'b0, imem_req}, 32'h1);
        chk("s3_drop_addr", imem_addr, 32'h0);
        cyc();
        @(negedge clk);
        chk("s3_new_addr", imem_addr, 32'h100);
        drain("s3");

        // 4: count=2, redirect with ack and pop in the same cycle
        apply_reset();
        lat = 1; budget = 2; deq_ready = 1'b0;
        @(posedge clk);
        wait_count(3'd2, "s4_pre_count");
        budget = 1; deq_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        chk("s4_redir_valid", {31'b0, deq_valid}, 32'h0);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("s4_count", 32'(count), 32'h0);
        chk("s4_valid", {31'b0, deq_valid}, 32'h0);
        chk("s4_addr", imem_addr, 32'h200);
        chk("s4_req", {31'b0, imem_req}, 32'h1);
        drain("s4");

        // 5: count=3, simultaneous push/pop across pointer wrap
        apply_reset();
        lat = 1; budget = 3; deq_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_exp(32'(4 * i));
        @(posedge clk);
        wait_count(3'd3, "s5_pre_count");
        budget = 6; deq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("s5_count_steady", 32'(count), 32'h3);
        end
        drain("s5");

        // 6: reset in the middle of a pending request
        apply_reset();
        lat = 3; budget = 1; deq_ready = 1'b1;
        push_exp(32'h0);
        @(posedge clk);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("s6_req_async", {31'b0, imem_req}, 32'h0);
        chk("s6_valid_async", {31'b0, deq_valid}, 32'h0);
        force_ack = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("s6_stale_ack_count", 32'(count), 32'h0);
        chk("s6_idle_req", {31'b0, imem_req}, 32'h0);
        cyc();
        force_ack = 1'b0;
        @(negedge clk);
        chk("s6_restart_addr", imem_addr, 32'h0);
        chk("s6_restart_req", {31'b0, imem_req}, 32'h1);
        drain("s6");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
